lsu_mem_arbiter: RTL and testbench

Per-core arbiter that shares one data-memory channel among the THREADS_PER_BLOCK per-thread LSUs.
- Sits between the LSU valid/ready ports and the core's data-memory interface.
- Grants one thread at a time, round-robin, and carries a read or write through to completion before the next grant.
- Returns read data to the granted LSU using the existing valid/ready hold-until-ready protocol.

---
 rtl/lsu_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory channel among per-thread LSUs
module lsu_mem_arbiter #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int ADDR_BITS         = 8,
    parameter int DATA_BITS         = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_read_valid,
    input  logic [THREADS_PER_BLOCK*ADDR_BITS-1:0] lsu_read_address,
    output logic [THREADS_PER_BLOCK-1:0]           lsu_read_ready,
    output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_read_data,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_write_valid,
    input  logic [THREADS_PER_BLOCK*ADDR_BITS-1:0] lsu_write_address,
    input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_write_data,
    output logic [THREADS_PER_BLOCK-1:0]           lsu_write_ready,
    output logic                                   mem_read_valid,
    output logic [ADDR_BITS-1:0]                   mem_read_address,
    input  logic                                   mem_read_ready,
    input  logic [DATA_BITS-1:0]                   mem_read_data,
    output logic                                   mem_write_valid,
    output logic [ADDR_BITS-1:0]                   mem_write_address,
    output logic [DATA_BITS-1:0]                   mem_write_data,
    input  logic                                   mem_write_ready,
    output logic                                   busy,
    output logic [$clog2(THREADS_PER_BLOCK)-1:0]   grant_id
);

    localparam int N  = THREADS_PER_BLOCK;
    localparam int GW = $clog2(THREADS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELEASE,
        WRITE_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic                   mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;
    logic [N-1:0]           lsu_read_ready_q, lsu_read_ready_d;
    logic [N-1:0]           lsu_write_ready_q, lsu_write_ready_d;
    logic [N*DATA_BITS-1:0] lsu_read_data_q, lsu_read_data_d;

    logic                   win_found;
    logic [GW-1:0]          win_idx;
    logic [GW:0]            sum;
    logic [GW-1:0]          next_ptr;

    // Search from rr_ptr upward with wrap; the first thread asking for anything wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (sum >= (GW+1)'(N)) begin
                sum = sum - (GW+1)'(N);
            end
            if (!win_found && (lsu_read_valid[sum[GW-1:0]] || lsu_write_valid[sum[GW-1:0]])) begin
                win_found = 1'b1;
                win_idx   = sum[GW-1:0];
            end
        end
    end

    assign next_ptr = (grant_q == GW'(N-1)) ? '0 : grant_q + 1'b1;

    // Next-state and registered-output logic; reads beat writes for the same thread
    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_d             = grant_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        lsu_read_ready_d    = lsu_read_ready_q;
        lsu_write_ready_d   = lsu_write_ready_q;
        lsu_read_data_d     = lsu_read_data_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    if (lsu_read_valid[win_idx]) begin
                        mem_read_address_d = lsu_read_address[win_idx*ADDR_BITS +: ADDR_BITS];
                        mem_read_valid_d   = 1'b1;
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_address_d = lsu_write_address[win_idx*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = lsu_write_data[win_idx*DATA_BITS +: DATA_BITS];
                        mem_write_valid_d   = 1'b1;
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    lsu_read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
                    lsu_read_ready_d[grant_q] = 1'b1;
                    state_d = READ_RELEASE;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d          = 1'b0;
                    lsu_write_ready_d[grant_q] = 1'b1;
                    state_d                    = WRITE_RELEASE;
                end
            end
            READ_RELEASE: begin
                if (!lsu_read_valid[grant_q]) begin
                    lsu_read_ready_d[grant_q] = 1'b0;
                    rr_ptr_d                  = next_ptr;
                    state_d                   = IDLE;
                end
            end
            WRITE_RELEASE: begin
                if (!lsu_write_valid[grant_q]) begin
                    lsu_write_ready_d[grant_q] = 1'b0;
                    rr_ptr_d                   = next_ptr;
                    state_d                    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight memory request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            lsu_read_ready_q    <= '0;
            lsu_write_ready_q   <= '0;
            lsu_read_data_q     <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            lsu_read_ready_q    <= lsu_read_ready_d;
            lsu_write_ready_q   <= lsu_write_ready_d;
            lsu_read_data_q     <= lsu_read_data_d;
        end
    end

    assign mem_read_valid    = mem_read_valid_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write_valid   = mem_write_valid_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_data    = mem_write_data_q;
    assign lsu_read_ready    = lsu_read_ready_q;
    assign lsu_write_ready   = lsu_write_ready_q;
    assign lsu_read_data     = lsu_read_data_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   lsu_read_valid;
    logic [N*8-1:0] lsu_read_address;
    logic [N-1:0]   lsu_read_ready;
    logic [N*8-1:0] lsu_read_data;
    logic [N-1:0]   lsu_write_valid;
    logic [N*8-1:0] lsu_write_address;
    logic [N*8-1:0] lsu_write_data;
    logic [N-1:0]   lsu_write_ready;
    logic           mem_read_valid;
    logic [7:0]     mem_read_address;
    logic           mem_read_ready = 1'b0;
    logic [7:0]     mem_read_data = 8'h00;
    logic           mem_write_valid;
    logic [7:0]     mem_write_address;
    logic [7:0]     mem_write_data;
    logic           mem_write_ready = 1'b0;
    logic           busy;
    logic [1:0]     grant_id;

    int checks = 0;
    int errors = 0;
    int mem_delay = 1;
    bit mem_stall = 1'b0;
    int rcnt = 0;
    int wcnt = 0;
    int rd_cycles = 0;
    int viol = 0;
    int rd_before;
    int glog[$];

    lsu_mem_arbiter #(.THREADS_PER_BLOCK(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .lsu_read_valid(lsu_read_valid), .lsu_read_address(lsu_read_address),
        .lsu_read_ready(lsu_read_ready), .lsu_read_data(lsu_read_data),
        .lsu_write_valid(lsu_write_valid), .lsu_write_address(lsu_write_address),
        .lsu_write_data(lsu_write_data), .lsu_write_ready(lsu_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Memory responder: answers after mem_delay cycles of valid, read data = addr ^ 0x4A
    always @(posedge clk) begin
        #1;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (mem_read_valid && !mem_stall) begin
            if (rcnt + 1 >= mem_delay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_read_address ^ 8'h4A;
                rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
        if (mem_write_valid && !mem_stall) begin
            if (wcnt + 1 >= mem_delay) begin
                mem_write_ready = 1'b1;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    end

    // Protocol watcher: exclusive memory valids, at most one ready, readies only while busy
    always @(negedge clk) begin
        if (mem_read_valid) rd_cycles++;
        if (mem_read_valid && mem_write_valid) viol++;
        if (!$onehot0({lsu_read_ready, lsu_write_ready})) viol++;
        if ((|lsu_read_ready || |lsu_write_ready) && !busy) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int t, input bit wr);
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = wr ? lsu_write_ready[t] : lsu_read_ready[t];
        end
        chk("wait_ready", seen, 1);
    endtask

    task automatic run(input int max);
        bit done = 1'b0;
        for (int c = 0; c < max && !done; c++) begin
            tick();
            for (int t = 0; t < N; t++) begin
                if (lsu_read_ready[t] && lsu_read_valid[t]) begin
                    glog.push_back(t);
                    lsu_read_valid[t] = 1'b0;
                end
                if (lsu_write_ready[t] && lsu_write_valid[t]) begin
                    glog.push_back(16 + t);
                    lsu_write_valid[t] = 1'b0;
                end
            end
            if (lsu_read_valid == '0 && lsu_write_valid == '0 && !busy) done = 1'b1;
        end
        chk("run_timeout", done, 1);
    endtask

    initial begin
        reset = 1'b0;
        lsu_read_valid = '0; lsu_read_address = '0;
        lsu_write_valid = '0; lsu_write_address = '0; lsu_write_data = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_mrv", mem_read_valid, 0);
        chk("rst_mwv", mem_write_valid, 0);
        chk("rst_ready", {lsu_read_ready, lsu_write_ready}, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_rdata", lsu_read_data, 0);
        reset = 1'b1;
        tick();

        // Single write, thread 0
        rd_before = rd_cycles;
        lsu_write_address[0 +: 8] = 8'h04;
        lsu_write_data[0 +: 8]    = 8'h33;
        lsu_write_valid[0]        = 1'b1;
        tick();
        chk("wr_mwv", mem_write_valid, 1);
        chk("wr_addr", mem_write_address, 8'h04);
        chk("wr_data", mem_write_data, 8'h33);
        chk("wr_grant", grant_id, 0);
        wait_rdy(0, 1'b1);
        chk("wr_ready", {lsu_read_ready, lsu_write_ready}, 8'b0000_0001);
        lsu_write_valid[0] = 1'b0;
        tick();
        chk("wr_ready_clr", lsu_write_ready, 0);
        chk("wr_idle", busy, 0);
        chk("wr_no_read", rd_cycles, rd_before);

        // Single read, thread 2, memory answers after 2 cycles
        mem_delay = 2;
        lsu_read_address[16 +: 8] = 8'h10;
        lsu_read_valid[2] = 1'b1;
        chk("rd_mrv_pre", mem_read_valid, 0);
        tick();
        chk("rd_mrv", mem_read_valid, 1);
        chk("rd_addr", mem_read_address, 8'h10);
        chk("rd_grant", grant_id, 2);
        chk("rd_busy", busy, 1);
        chk("rd_no_ready", lsu_read_ready, 0);
        wait_rdy(2, 1'b0);
        chk("rd_ready", lsu_read_ready, 4'b0100);
        chk("rd_data", lsu_read_data[16 +: 8], 8'h5A);
        lsu_read_valid[2] = 1'b0;
        tick();
        chk("rd_ready_clr", lsu_read_ready, 0);
        chk("rd_idle", busy, 0);
        chk("rd_grant_hold", grant_id, 2);
        mem_delay = 1;

        // rr_ptr should now be 3: thread 3 beats thread 0
        glog.delete();
        lsu_read_address[0 +: 8] = 8'h20; lsu_read_address[24 +: 8] = 8'h23;
        lsu_read_valid = 4'b1001;
        run(60);
        chk("rr3_n", glog.size(), 2);
        chk("rr3_0", glog[0], 3);
        chk("rr3_1", glog[1], 0);
        chk("rr3_d0", lsu_read_data[0 +: 8], 8'h6A);
        chk("rr3_d3", lsu_read_data[24 +: 8], 8'h69);
        chk("rr3_d2_kept", lsu_read_data[16 +: 8], 8'h5A);

        // Mixed: thread 1 read+write, thread 3 write, starting at rr_ptr 1
        glog.delete();
        lsu_read_address[8 +: 8]   = 8'h31;
        lsu_write_address[8 +: 8]  = 8'h51; lsu_write_data[8 +: 8]  = 8'hA1;
        lsu_write_address[24 +: 8] = 8'h53; lsu_write_data[24 +: 8] = 8'hB3;
        lsu_read_valid  = 4'b0010;
        lsu_write_valid = 4'b1010;
        run(80);
        chk("mix_n", glog.size(), 3);
        chk("mix_0", glog[0], 8'h01);
        chk("mix_1", glog[1], 8'h13);
        chk("mix_2", glog[2], 8'h11);
        chk("mix_d1", lsu_read_data[8 +: 8], 8'h7B);
        chk("mix_viol", viol, 0);

        // Contention from rr_ptr 2
        glog.delete();
        for (int t = 0; t < N; t++) lsu_read_address[t*8 +: 8] = 8'h80 + 8'(t);
        lsu_read_valid = 4'b1111;
        run(100);
        chk("c2_n", glog.size(), 4);
        chk("c2_0", glog[0], 2);
        chk("c2_1", glog[1], 3);
        chk("c2_2", glog[2], 0);
        chk("c2_3", glog[3], 1);
        chk("c2_data", lsu_read_data, 32'hC9C8CBCA);

        // Stall: memory withholds ready for 20 cycles
        glog.delete();
        mem_stall = 1'b1;
        lsu_read_address[8 +: 8] = 8'h77;
        lsu_read_valid[1] = 1'b1;
        tick();
        chk("st_mrv", mem_read_valid, 1);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("st_hold", {mem_read_valid, busy, lsu_read_ready, lsu_write_ready}, 10'b11_0000_0000);
        end
        mem_stall = 1'b0;
        run(20);
        chk("st_n", glog.size(), 1);
        chk("st_0", glog[0], 1);
        chk("st_data", lsu_read_data[8 +: 8], 8'h3D);

        // Reset while waiting on memory
        mem_stall = 1'b1;
        lsu_read_address[0 +: 8] = 8'h99;
        lsu_read_valid[0] = 1'b1;
        tick();
        chk("rm_mrv", mem_read_valid, 1);
        reset = 1'b0;
        tick();
        chk("rm_mrv_clr", mem_read_valid, 0);
        chk("rm_mwv", mem_write_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_grant", grant_id, 0);
        chk("rm_ready", {lsu_read_ready, lsu_write_ready}, 0);
        chk("rm_rdata", lsu_read_data, 0);
        lsu_read_valid = '0;
        reset = 1'b1;
        mem_stall = 1'b0;
        tick();

        // Contention after reset: rr_ptr back to 0
        glog.delete();
        for (int t = 0; t < N; t++) lsu_read_address[t*8 +: 8] = 8'h40 + 8'(t);
        lsu_read_valid = 4'b1111;
        run(100);
        chk("c0_n", glog.size(), 4);
        chk("c0_0", glog[0], 0);
        chk("c0_1", glog[1], 1);
        chk("c0_2", glog[2], 2);
        chk("c0_3", glog[3], 3);
        chk("c0_data", lsu_read_data, 32'h09080B0A);
        chk("final_viol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
